// File: rtl/clkgen_prog_pkg.sv
// Shared types and constants for the DCM_CLKGEN programming sequencer.
package clkgen_prog_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      GO,
      WAIT_BUSY_HI,
      WAIT_BUSY_LO,
      WAIT_LOCK,
      REPORT
   } state_t;

   // ASCII status bytes returned to the UART TX FIFO
   localparam logic [7:0] STAT_OK         = 8'h4B;  // 'K'
   localparam logic [7:0] STAT_ERR        = 8'h45;  // 'E'
   localparam logic [7:0] STAT_BUSY_TO    = 8'h42;  // 'B'
   localparam logic [7:0] STAT_LOCK_TO    = 8'h54;  // 'T'
   localparam logic [7:0] STAT_RETRY_FAIL = 8'h52;  // 'R'

   // Power-on DCM_CLKGEN setting: M=31, D=21 (codes are value minus 1)
   localparam logic [7:0] RST_M = 8'd30;
   localparam logic [7:0] RST_D = 8'd20;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/clkgen_prog_ctrl_lock_qualifier.sv
// LOCKED synchroniser followed by a run-length counter; lock_qual is high on
// the cycle the synchronised LOCKED completes LOCK_STABLE consecutive highs.
module lock_qualifier
   import clkgen_prog_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_STABLE = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic lock_async,
   input  logic clear,
   output logic lock_qual
);

   localparam int SW = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int RW = $clog2(LOCK_STABLE) + 1;

   logic [SW-1:0] sync_reg;
   logic [RW-1:0] run_reg;
   logic [RW-1:0] run_next;
   logic          lock_sync;

   assign lock_sync = sync_reg[SW-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= '0;
         run_reg  <= '0;
      end else begin
         sync_reg <= {sync_reg[SW-2:0], lock_async};
         run_reg  <= run_next;
      end
   end

   // run_reg counts earlier high cycles, so the current high cycle completes the run
   always_comb begin
      run_next = run_reg;
      if (clear || !lock_sync)
         run_next = '0;
      else if (run_reg != RW'(LOCK_STABLE))
         run_next = run_reg + 1'b1;
   end

   assign lock_qual = lock_sync && !clear && (run_reg >= RW'(LOCK_STABLE - 1));

endmodule

// File: rtl/clkgen_prog_ctrl.sv
// Sequencer from M/D request to DCM_CLKGEN programming, lock qualification and status byte.
// Optional automatic single retry on timeout when CLKGEN_PROG_RETRY_EN is defined.
module clkgen_prog_ctrl
   import clkgen_prog_pkg::*;
#(
   parameter int LOCK_TIMEOUT = 500000,
   parameter int BUSY_TIMEOUT = 4096,
   parameter int LOCK_STABLE  = 256,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_m,
   input  logic [7:0] req_d,
   output logic [7:0] prog_m,
   output logic [7:0] prog_d,
   output logic       prog_go,
   input  logic       prog_busy,
   input  logic       dcm_locked,
   input  logic       stat_full,
   output logic       stat_wr,
   output logic [7:0] stat_data,
   output logic       lock_ok
);

   localparam int CNT_W = $clog2(max3(LOCK_TIMEOUT, BUSY_TIMEOUT, LOCK_STABLE)) + 1;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
   logic [7:0]         pend_m_reg, pend_m_next;
   logic [7:0]         pend_d_reg, pend_d_next;
   logic [7:0]         prog_m_reg, prog_m_next;
   logic [7:0]         prog_d_reg, prog_d_next;
   logic [7:0]         stat_data_reg, stat_data_next;
   logic               lock_ok_reg, lock_ok_next;
   logic               fail;
   logic               lock_qual;
`ifdef CLKGEN_PROG_RETRY_EN
   logic               retry_reg, retry_next;
`endif

   lock_qualifier #(
      .SYNC_STAGES (SYNC_STAGES),
      .LOCK_STABLE (LOCK_STABLE)
   ) u_lock_qualifier (
      .clk        (clk),
      .rst        (rst),
      .lock_async (dcm_locked),
      .clear      (state_reg != WAIT_LOCK),
      .lock_qual  (lock_qual)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         pend_m_reg    <= '0;
         pend_d_reg    <= '0;
         prog_m_reg    <= RST_M;
         prog_d_reg    <= RST_D;
         stat_data_reg <= '0;
         lock_ok_reg   <= 1'b0;
`ifdef CLKGEN_PROG_RETRY_EN
         retry_reg     <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         pend_m_reg    <= pend_m_next;
         pend_d_reg    <= pend_d_next;
         prog_m_reg    <= prog_m_next;
         prog_d_reg    <= prog_d_next;
         stat_data_reg <= stat_data_next;
         lock_ok_reg   <= lock_ok_next;
`ifdef CLKGEN_PROG_RETRY_EN
         retry_reg     <= retry_next;
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      pend_m_next    = pend_m_reg;
      pend_d_next    = pend_d_reg;
      prog_m_next    = prog_m_reg;
      prog_d_next    = prog_d_reg;
      stat_data_next = stat_data_reg;
      lock_ok_next   = lock_ok_reg;
      fail           = 1'b0;
      cnt_inc        = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
`ifdef CLKGEN_PROG_RETRY_EN
      retry_next     = retry_reg;
`endif

      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               pend_m_next = req_m;
               pend_d_next = req_d;
               state_next  = CHECK;
            end
         end
         CHECK: begin
            // multiply code 0 (M=1) is rejected by DCM_CLKGEN
            if (pend_m_reg == 8'd0) begin
               stat_data_next = STAT_ERR;
               state_next     = REPORT;
            end else begin
               prog_m_next = pend_m_reg;
               prog_d_next = pend_d_reg;
               state_next  = GO;
            end
         end
         GO: begin
            lock_ok_next = 1'b0;
            cnt_next     = '0;
            state_next   = WAIT_BUSY_HI;
         end
         WAIT_BUSY_HI: begin
            if (prog_busy) begin
               cnt_next   = '0;
               state_next = WAIT_BUSY_LO;
            end else if (cnt_reg == CNT_W'(BUSY_TIMEOUT - 1))
               fail = 1'b1;
            else
               cnt_next = cnt_inc;
         end
         WAIT_BUSY_LO: begin
            if (!prog_busy) begin
               cnt_next   = '0;
               state_next = WAIT_LOCK;
            end else if (cnt_reg == CNT_W'(BUSY_TIMEOUT - 1))
               fail = 1'b1;
            else
               cnt_next = cnt_inc;
         end
         WAIT_LOCK: begin
            // qualified lock takes priority over a coincident timeout
            if (lock_qual) begin
               lock_ok_next   = 1'b1;
               stat_data_next = STAT_OK;
               state_next     = REPORT;
            end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1))
               fail = 1'b1;
            else
               cnt_next = cnt_inc;
         end
         REPORT: begin
            if (!stat_full)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (fail) begin
`ifdef CLKGEN_PROG_RETRY_EN
         if (retry_reg) begin
            stat_data_next = STAT_RETRY_FAIL;
            state_next     = REPORT;
         end else begin
            retry_next = 1'b1;
            state_next = GO;
         end
`else
         stat_data_next = (state_reg == WAIT_LOCK) ? STAT_LOCK_TO : STAT_BUSY_TO;
         state_next     = REPORT;
`endif
      end

`ifdef CLKGEN_PROG_RETRY_EN
      if (state_next == IDLE)
         retry_next = 1'b0;
`endif
   end

   assign req_ready = (state_reg == IDLE);
   assign prog_go   = (state_reg == GO);
   assign stat_wr   = (state_reg == REPORT) && !stat_full;
   assign prog_m    = prog_m_reg;
   assign prog_d    = prog_d_reg;
   assign stat_data = stat_data_reg;
   assign lock_ok   = lock_ok_reg;

endmodule

// File: tb/tb_clkgen_prog_ctrl.sv
// Directed table-driven bench for clkgen_prog_ctrl with a programmer/DCM behavioural model.
module tb_clkgen_prog_ctrl;

   localparam int LT = 3000;
   localparam int BT = 256;
   localparam int LS = 256;
   localparam int SS = 2;
`ifdef CLKGEN_PROG_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif
   localparam logic [7:0] EXP_T   = RETRY ? 8'h52 : 8'h54;
   localparam logic [7:0] EXP_B   = RETRY ? 8'h52 : 8'h42;
   localparam int         BAD_GOS = RETRY ? 2 : 1;

   typedef enum int {K_OK, K_ERR, K_LOCKTO, K_BUSYTO} kind_t;
   typedef struct {
      logic [7:0] m;
      logic [7:0] d;
      bit         busy_en;
      int         lock_mode;
      kind_t      kind;
      logic [7:0] exp_byte;
      bit         exp_lock;
      logic [7:0] exp_pm;
      logic [7:0] exp_pd;
      int         exp_gos;
   } vec_t;
   localparam int NV = 6;
   vec_t vecs[NV];

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_m;
   logic [7:0] req_d;
   logic [7:0] prog_m;
   logic [7:0] prog_d;
   logic       prog_go;
   logic       prog_busy  = 1'b0;
   logic       dcm_locked = 1'b0;
   logic       stat_full;
   logic       stat_wr;
   logic [7:0] stat_data;
   logic       lock_ok;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int go_count = 0, go_base = 0, go_first_cyc = 0, go_last_cyc = 0;
   int wr_count = 0, wr_cyc = 0;
   logic [7:0] wr_byte = 8'h00;
   int busy_en = 0, lock_mode = 0;
   int model_ph = 0, model_pc = 0;
   int busy_fall_cyc = 0, lock_rise_cyc = 0;
   int accept_cyc = 0;

   clkgen_prog_ctrl #(
      .LOCK_TIMEOUT (LT),
      .BUSY_TIMEOUT (BT),
      .LOCK_STABLE  (LS),
      .SYNC_STAGES  (SS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_m      (req_m),
      .req_d      (req_d),
      .prog_m     (prog_m),
      .prog_d     (prog_d),
      .prog_go    (prog_go),
      .prog_busy  (prog_busy),
      .dcm_locked (dcm_locked),
      .stat_full  (stat_full),
      .stat_wr    (stat_wr),
      .stat_data  (stat_data),
      .lock_ok    (lock_ok)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (prog_go) begin
         if (go_count == go_base) go_first_cyc = cyc;
         go_last_cyc = cyc;
         go_count++;
      end
      if (stat_wr) begin
         wr_count++;
         wr_cyc  = cyc;
         wr_byte = stat_data;
      end
   end

   // Programmer + DCM model: BUSY 3 cycles after GO for 200 cycles, then LOCKED per lock_mode
   always begin
      @(posedge clk);
      #1;
      model_pc++;
      case (model_ph)
         1: if (model_pc == 3) begin
               prog_busy = 1'b1; model_ph = 2; model_pc = 0;
            end
         2: if (model_pc == 200) begin
               prog_busy = 1'b0; busy_fall_cyc = cyc; model_ph = 3; model_pc = 0;
            end
         3: begin
               if (lock_mode == 1 && model_pc == 50) begin
                  dcm_locked = 1'b1; lock_rise_cyc = cyc;
               end else if (lock_mode == 2 && (model_pc % 100) == 0)
                  dcm_locked = !dcm_locked;
            end
         default: ;
      endcase
      if (prog_go) begin
         model_ph   = (busy_en != 0) ? 1 : 0;
         model_pc   = 0;
         dcm_locked = 1'b0;
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: cycles=%0d required finish before 60000", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic issue(input logic [7:0] m, input logic [7:0] d);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("req_ready_before_issue", int'(req_ready), 1);
      go_base    = go_count;
      req_m      = m;
      req_d      = d;
      req_valid  = 1'b1;
      accept_cyc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_write(input int base, input int budget, output bit ok);
      int n = 0;
      while (wr_count == base && n < budget) begin
         @(posedge clk); n++;
      end
      ok = (wr_count != base);
   endtask

   initial begin
      int  wbase;
      int  n;
      int  drop_cyc;
      bit  ok;

      rst = 1'b1; req_valid = 1'b0; req_m = '0; req_d = '0; stat_full = 1'b0;
      vecs[0] = '{8'h00, 8'h05, 1'b1, 0, K_ERR,    8'h45, 1'b0, 8'd30,  8'd20,  0};
      vecs[1] = '{8'd49, 8'd24, 1'b1, 1, K_OK,     8'h4B, 1'b1, 8'd49,  8'd24,  1};
      vecs[2] = '{8'h00, 8'h09, 1'b1, 1, K_ERR,    8'h45, 1'b1, 8'd49,  8'd24,  0};
      vecs[3] = '{8'h10, 8'h03, 1'b1, 2, K_LOCKTO, EXP_T, 1'b0, 8'h10,  8'h03,  BAD_GOS};
      vecs[4] = '{8'h20, 8'h07, 1'b0, 0, K_BUSYTO, EXP_B, 1'b0, 8'h20,  8'h07,  BAD_GOS};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1, K_OK,     8'h4B, 1'b1, 8'hFF,  8'hFF,  1};

      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", int'(req_ready), 1);
      chk("reset_prog_go",   int'(prog_go), 0);
      chk("reset_stat_wr",   int'(stat_wr), 0);
      chk("reset_prog_m",    int'(prog_m), 30);
      chk("reset_prog_d",    int'(prog_d), 20);
      chk("reset_stat_data", int'(stat_data), 0);
      chk("reset_lock_ok",   int'(lock_ok), 0);
      $display("reset: prog_m=%0d prog_d=%0d req_ready=%0b", prog_m, prog_d, req_ready);

      @(posedge clk); #1;
      for (int i = 0; i < NV; i++) begin
         busy_en   = int'(vecs[i].busy_en);
         lock_mode = vecs[i].lock_mode;
         repeat (2) @(posedge clk);
         #1;
         wbase = wr_count;
         issue(vecs[i].m, vecs[i].d);
         wait_write(wbase, 20000, ok);
         chk($sformatf("v%0d_write_seen", i), int'(ok), 1);
         repeat (4) @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_wr_byte", i),   int'(wr_byte), int'(vecs[i].exp_byte));
         chk($sformatf("v%0d_stat_data", i), int'(stat_data), int'(vecs[i].exp_byte));
         chk($sformatf("v%0d_lock_ok", i),   int'(lock_ok), int'(vecs[i].exp_lock));
         chk($sformatf("v%0d_prog_m", i),    int'(prog_m), int'(vecs[i].exp_pm));
         chk($sformatf("v%0d_prog_d", i),    int'(prog_d), int'(vecs[i].exp_pd));
         chk($sformatf("v%0d_wr_count", i),  wr_count - wbase, 1);
         chk($sformatf("v%0d_go_count", i),  go_count - go_base, vecs[i].exp_gos);
         if (vecs[i].exp_gos > 0)
            chk($sformatf("v%0d_accept_to_go", i), go_first_cyc - accept_cyc, 2);
         case (vecs[i].kind)
            K_OK:     chk($sformatf("v%0d_lock_to_wr", i), wr_cyc - lock_rise_cyc, LS + SS);
            K_LOCKTO: chk($sformatf("v%0d_busyfall_to_wr", i), wr_cyc - busy_fall_cyc, LT + 1);
            K_BUSYTO: chk($sformatf("v%0d_go_to_wr", i), wr_cyc - go_last_cyc, BT + 1);
            default:  chk($sformatf("v%0d_accept_to_wr", i), wr_cyc - accept_cyc, 2);
         endcase
         $display("vec %0d: m=%0d d=%0d byte=0x%02h lock_ok=%0b gos=%0d",
                  i, vecs[i].m, vecs[i].d, wr_byte, lock_ok, go_count - go_base);
         @(posedge clk); #1;
      end

      // reset while waiting for lock: back to IDLE with no status byte
      busy_en = 1; lock_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      wbase = wr_count;
      issue(8'h40, 8'h10);
      n = 0;
      while (go_count == go_base && n < 100) begin
         @(posedge clk); #1; n++;
      end
      repeat (2) @(posedge clk);
      #1;
      n = 0;
      while (model_ph != 3 && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      chk("rst_reached_wait_lock", int'(model_ph == 3), 1);
      repeat (20) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_req_ready", int'(req_ready), 1);
      chk("rst_prog_m",    int'(prog_m), 30);
      chk("rst_lock_ok",   int'(lock_ok), 0);
      repeat (300) @(posedge clk);
      @(negedge clk);
      chk("rst_no_status", wr_count - wbase, 0);
      chk("rst_idle_ready", int'(req_ready), 1);
      $display("reset in WAIT_LOCK: writes=%0d req_ready=%0b", wr_count - wbase, req_ready);

      // backpressure: status byte held until the FIFO has room
      @(posedge clk); #1;
      stat_full = 1'b1;
      wbase = wr_count;
      issue(8'h00, 8'h01);
      repeat (1000) @(posedge clk);
      #1;
      chk("bp_no_write_while_full", wr_count - wbase, 0);
      chk("bp_not_ready_in_report", int'(req_ready), 0);
      stat_full = 1'b0;
      drop_cyc  = cyc;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("bp_single_write", wr_count - wbase, 1);
      chk("bp_write_cycle",  wr_cyc - drop_cyc, 0);
      chk("bp_write_byte",   int'(wr_byte), 8'h45);
      chk("bp_ready_after",  int'(req_ready), 1);
      $display("backpressure: writes=%0d byte=0x%02h", wr_count - wbase, wr_byte);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clkgen_prog_ctrl.md
Name: clkgen_prog_ctrl

Overview:
- Sequencer between the serial command decoder and the DCM_CLKGEN SPI programmer.
- Accepts a new M/D request, validates it, and issues a single-cycle GO to the programmer.
- Tracks programmer BUSY, then waits for a qualified DCM lock with a timeout.
- Returns a one-byte ASCII status for the UART TX FIFO.
- Runs entirely on the 50 MHz programming clock.

Parameters:
- LOCK_TIMEOUT, 500000: cycles allowed in WAIT_LOCK before declaring timeout (10 ms at 50 MHz).
- BUSY_TIMEOUT, 4096: cycles allowed for BUSY to rise, and again for it to fall.
- LOCK_STABLE, 256: consecutive synchronised LOCKED-high cycles required to accept lock.
- SYNC_STAGES, 2: flip-flop depth of the LOCKED synchroniser (minimum 2).

Ports:
- clk  in  1  programming clock, same net as the DCM PROGCLK.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  a request is present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_m  in  8  DCM multiply minus 1.
- req_d  in  8  DCM divide minus 1.
- prog_m  out  8  M code to the SPI programmer.
- prog_d  out  8  D code to the SPI programmer.
- prog_go  out  1  one-cycle start pulse to the programmer.
- prog_busy  in  1  programmer busy.
- dcm_locked  in  1  DCM LOCKED, asynchronous to clk.
- stat_full  in  1  TX FIFO full.
- stat_wr  out  1  TX FIFO write strobe.
- stat_data  out  8  status byte.
- lock_ok  out  1  last programming reached qualified lock.

Behaviour:
Reset values:
- state=IDLE, req_ready=1, prog_go=0, stat_wr=0.
- prog_m=8'd30, prog_d=8'd20 (power-on 31/21).
- stat_data=0, lock_ok=0.
- Counters and synchroniser cleared.

Request acceptance:
- A request is taken on any cycle with req_valid && req_ready.
- req_m/req_d are registered into pending registers and the FSM moves to CHECK.

CHECK (1 cycle):
- If req_m==0 (multiply 1 is illegal for DCM_CLKGEN): status='E' (0x45), go to REPORT. prog_m/prog_d are not updated.
- Otherwise copy the pending values to prog_m/prog_d and go to GO.

GO:
- prog_go=1 for exactly one cycle, lock_ok cleared, counter cleared, go to WAIT_BUSY_HI.

WAIT_BUSY_HI:
- prog_busy=1: go to WAIT_BUSY_LO, counter cleared.
- Counter reaches BUSY_TIMEOUT-1: status='B' (0x42), go to REPORT.

WAIT_BUSY_LO:
- prog_busy=0: go to WAIT_LOCK, counter cleared.
- Counter reaches BUSY_TIMEOUT-1: status='B', go to REPORT.

WAIT_LOCK:
- Stable counter increments while the synchronised lock is 1 and resets to 0 on any 0.
- Stable counter reaches LOCK_STABLE: lock_ok=1, status='K' (0x4B), go to REPORT.
- Timeout counter reaches LOCK_TIMEOUT-1 first: status='T' (0x54), go to REPORT.
- If stable completion and timeout land on the same cycle, lock wins ('K').

REPORT:
- Hold stat_data.
- stat_wr=1 for exactly one cycle, on the first cycle with stat_full=0, then go to IDLE.
- While stat_full=1, stay in REPORT with stat_wr=0. There is no timeout; the byte is never dropped.

General rules:
- All counters saturate and never wrap.
- Counter widths are $clog2 of the largest parameter, plus 1.
- req_valid outside IDLE is ignored; the upstream holds it until req_ready.
- rst asserted in any state returns to IDLE the next cycle.
  - Any in-flight SPI transfer is abandoned; the programmer has its own reset.
  - No status byte is emitted for the aborted request.
- Latency from accept to prog_go: exactly 2 cycles (CHECK, then GO).

Optional Feature:
- Macro: CLKGEN_PROG_RETRY_EN.
- Defined:
  - A 'T' or 'B' outcome triggers one automatic re-issue: return to GO with the same prog_m/prog_d and a retry flag set.
  - Status is 'K' on success after retry, 'R' (0x52) on a second failure.
  - The retry flag clears on entry to IDLE.
- Undefined:
  - No retry; failure is reported immediately as 'T' or 'B'.
  - The 'R' code is never produced.

Decomposition:
- Package clkgen_prog_pkg holds:
  - FSM state enum: IDLE, CHECK, GO, WAIT_BUSY_HI, WAIT_BUSY_LO, WAIT_LOCK, REPORT.
  - Status byte constants: STAT_OK, STAT_ERR, STAT_BUSY_TO, STAT_LOCK_TO, STAT_RETRY_FAIL.
  - Reset M/D constants.
- One sub-module, lock_qualifier: SYNC_STAGES synchroniser plus the LOCK_STABLE run counter.
  - Inputs: clk, rst, async lock, clear.
  - Output: one-bit qualified lock.

Test Plan:
- Reset: after rst, prog_m=30, prog_d=20, req_ready=1, stat_wr=0, prog_go=0.
- Nominal:
  - Stimulus: req_m=49, req_d=24; BUSY high 3 cycles after go for 200 cycles; LOCKED high 50 cycles later.
  - Required: prog_go pulses exactly 2 cycles after accept, exactly once.
  - Required: stat_wr with 0x4B occurs LOCK_STABLE+SYNC_STAGES cycles after LOCKED rises; lock_ok=1.
- Invalid: req_m=0 → no prog_go, single stat_wr 0x45, prog_m unchanged at 30.
- Glitchy lock:
  - Stimulus: LOCKED toggles every 100 cycles and never stays high for 256.
  - Required: 0x54 after LOCK_TIMEOUT; lock_ok=0. With CLKGEN_PROG_RETRY_EN: two prog_go pulses, then 0x52.
- Busy timeout: prog_busy never rises → 0x42 after BUSY_TIMEOUT cycles.
- Backpressure and reset:
  - stat_full held high for 1000 cycles in REPORT → stat_wr only on the first cycle after it drops.
  - rst in WAIT_LOCK → IDLE next cycle, no status byte, req_ready=1.
